// File: rtl/sync_fifo_cfg.sv
// Single-clock FIFO with registered or first-word-fall-through read port,
// configurable almost-full/almost-empty thresholds and overflow/underflow pulses.
module sync_fifo_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter bit FWFT       = 1'b0,
   parameter int AFULL_TH   = 14,
   parameter int AEMPTY_TH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  overflow_q, underflow_q;
   logic                  wr_acc, rd_acc;

   // All status flags come from the registered count, so they never glitch.
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_C);
   assign almost_empty = (count_q <= AEMPTY_C);
   assign data_count   = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= wr_en & full;
         underflow_q <= rd_en & empty;
      end
   end

   // NOTE: storage has no reset; the count keeps unwritten words from ever being read out.
   always_ff @(posedge clk) begin
      if (rst_n && wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   generate
      if (FWFT) begin : g_fwft
         assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
         assign rd_valid = ~empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] rd_data_q;
         logic                  rd_valid_q;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Scoreboard bench: one standard-read and one FWFT instance share stimulus and
// are compared every cycle against a queue-based model of the FIFO.
module tb_sync_fifo_cfg;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int AF0   = 14;
   localparam int AE0   = 2;
   localparam int AF1   = 16;
   localparam int AE1   = 0;

   logic          clk;
   logic          rst_n;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] wr_data;

   logic [DW-1:0] s_rd_data, f_rd_data;
   logic          s_rd_valid, f_rd_valid;
   logic          s_full, f_full, s_empty, f_empty;
   logic          s_afull, f_afull, s_aempty, f_aempty;
   logic [AW:0]   s_count, f_count;
   logic          s_ovf, f_ovf, s_unf, f_unf;

   typedef struct {
      int            due;
      int            cnt;
      bit            full;
      bit            empty;
      bit            af0;
      bit            ae0;
      bit            af1;
      bit            ae1;
      bit            ovf;
      bit            unf;
      bit            valid;
      logic [DW-1:0] hold;
      bit            f_valid;
      logic [DW-1:0] f_data;
   } exp_t;

   exp_t          status_q[$];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] model_q[$];
   logic [DW-1:0] last_rd = '0;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;

   sync_fifo_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0),
                   .AFULL_TH(AF0), .AEMPTY_TH(AE0)) u_std (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty), .data_count(s_count),
      .overflow(s_ovf), .underflow(s_unf));

   sync_fifo_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1),
                   .AFULL_TH(AF1), .AEMPTY_TH(AE1)) u_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .data_count(f_count),
      .overflow(f_ovf), .underflow(f_unf));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of requests and record what the FIFO must show after the edge.
   task automatic step(input bit rst, input bit wr, input logic [DW-1:0] wd, input bit rd);
      exp_t e;
      int   n;
      bit   was_full, was_empty;
      rst_n   = ~rst;
      wr_en   = wr;
      wr_data = wd;
      rd_en   = rd;
      e.due   = cyc + 1;
      if (rst) begin
         model_q.delete();
         last_rd = '0;
         e.ovf   = 1'b0;
         e.unf   = 1'b0;
         e.valid = 1'b0;
      end else begin
         was_full  = (model_q.size() == DEPTH);
         was_empty = (model_q.size() == 0);
         e.ovf     = wr && was_full;
         e.unf     = rd && was_empty;
         e.valid   = rd && !was_empty;
         if (e.valid) begin
            last_rd = model_q.pop_front();
            rd_q.push_back(last_rd);
         end
         if (wr && !was_full) model_q.push_back(wd);
      end
      n         = model_q.size();
      e.cnt     = n;
      e.full    = (n == DEPTH);
      e.empty   = (n == 0);
      e.af0     = (n >= AF0);
      e.ae0     = (n <= AE0);
      e.af1     = (n >= AF1);
      e.ae1     = (n <= AE1);
      e.hold    = last_rd;
      e.f_valid = (n != 0);
      e.f_data  = (n != 0) ? model_q[0] : '0;
      status_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares status every cycle and read words whenever rd_valid is shown.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (status_q.size() > 0 && status_q[0].due == cyc) begin
            e = status_q.pop_front();
            check("data_count", 32'(s_count), 32'(e.cnt));
            check("full", 32'(s_full), 32'(e.full));
            check("empty", 32'(s_empty), 32'(e.empty));
            check("almost_full", 32'(s_afull), 32'(e.af0));
            check("almost_empty", 32'(s_aempty), 32'(e.ae0));
            check("overflow", 32'(s_ovf), 32'(e.ovf));
            check("underflow", 32'(s_unf), 32'(e.unf));
            check("rd_valid", 32'(s_rd_valid), 32'(e.valid));
            if (!e.valid) check("rd_data_hold", 32'(s_rd_data), 32'(e.hold));
            check("fwft_data_count", 32'(f_count), 32'(e.cnt));
            check("fwft_full", 32'(f_full), 32'(e.full));
            check("fwft_empty", 32'(f_empty), 32'(e.empty));
            check("fwft_almost_full", 32'(f_afull), 32'(e.af1));
            check("fwft_almost_empty", 32'(f_aempty), 32'(e.ae1));
            check("fwft_overflow", 32'(f_ovf), 32'(e.ovf));
            check("fwft_underflow", 32'(f_unf), 32'(e.unf));
            check("fwft_rd_valid", 32'(f_rd_valid), 32'(e.f_valid));
            check("fwft_rd_data", 32'(f_rd_data), 32'(e.f_data));
         end
         if (s_rd_valid === 1'b1) begin
            if (rd_q.size() == 0) check("rd_valid_unexpected", 32'(s_rd_valid), 32'd0);
            else check("rd_data", 32'(s_rd_data), 32'(rd_q.pop_front()));
         end
      end
   end

   initial begin
      int wait_cyc;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;

      // Reset, including a reset cycle with requests that must be ignored.
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 8'hFF, 1'b1);

      // Fill 0x01..0x10, then a write into a full FIFO.
      for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
      step(1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Drain in order, then a read from an empty FIFO.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Empty with simultaneous write and read: write wins, read rejected.
      step(1'b0, 1'b1, 8'hA5, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Single word into an empty FIFO: visible on the FWFT port with no rd_en.
      step(1'b0, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Full with simultaneous write and read: read wins, write rejected.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
      step(1'b0, 1'b1, 8'hEE, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

      // Mixed traffic across pointer wrap, then a mid-stream reset with requests.
      for (int i = 0; i < 40; i++)
         step(1'b0, ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 40));
      step(1'b1, 1'b1, 8'h99, 1'b1);
      step(1'b0, 1'b1, 8'h77, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0);

      // Biased random phases to hit full/empty boundaries repeatedly.
      for (int i = 0; i < 100; i++)
         step(1'b0, ($urandom_range(0, 99) < 85), 8'($urandom), ($urandom_range(0, 99) < 25));
      for (int i = 0; i < 100; i++)
         step(1'b0, ($urandom_range(0, 99) < 25), 8'($urandom), ($urandom_range(0, 99) < 85));
      for (int i = 0; i < 100; i++)
         step(1'b0, ($urandom_range(0, 99) < 50), 8'($urandom), ($urandom_range(0, 99) < 50));
      step(1'b0, 1'b0, 8'h00, 1'b0);

      wait_cyc = 0;
      while (status_q.size() > 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      #1;
      check("status_queue_drained", 32'(status_q.size()), 32'd0);
      check("read_queue_drained", 32'(rd_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sync_fifo_cfg.md
SYNC_FIFO_CFG -- requirements
Module: sync_fifo_cfg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_TH, 14, almost_full threshold, legal range 1..DEPTH.
- AEMPTY_TH, 2, almost_empty threshold, legal range 0..DEPTH-1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, reset; synchronous, active-low.
- wr_en, in, 1, write request.
- wr_data, in, DATA_WIDTH, write word.
- rd_en, in, 1, read request (pop/ack in FWFT mode).
- rd_data, out, DATA_WIDTH, read word.
- rd_valid, out, 1, rd_data holds a valid word.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
- almost_full, out, 1, count >= AFULL_TH.
- almost_empty, out, 1, count <= AEMPTY_TH.
- data_count, out, ADDR_WIDTH+1, words stored (0..DEPTH).
- overflow, out, 1, one-cycle pulse: write rejected.
- underflow, out, 1, one-cycle pulse: read rejected.

Function
REQ-003 A write SHALL be accepted iff wr_en=1 and full=0 at the edge; full SHALL block writes even when a read is accepted in the same cycle.
REQ-004 A read SHALL be accepted iff rd_en=1 and empty=0 at the edge; empty SHALL block reads even when a write is accepted in the same cycle.
REQ-005 An accepted write SHALL store wr_data at wr_ptr and advance wr_ptr by 1, modulo DEPTH.
REQ-006 An accepted read SHALL advance rd_ptr by 1, modulo DEPTH; wrap-around SHALL occur only on an accepted access, never on pointer value alone.
REQ-007 data_count SHALL be +1 on write only, -1 on read only, and unchanged when both or neither are accepted; it SHALL never exceed DEPTH or go below 0.
REQ-008 full, empty, almost_full and almost_empty SHALL be decoded from the registered data_count and SHALL be valid in the same cycle as the count.
REQ-009 With FWFT=0, an accepted read SHALL register mem[rd_ptr] into rd_data with 1-cycle latency; rd_valid SHALL pulse high for exactly that cycle; rd_data SHALL hold its last value otherwise.
REQ-010 With FWFT=1, rd_data SHALL present the head word combinationally from storage and rd_valid SHALL equal ~empty, giving 0-cycle latency; rd_data SHALL be 0 while empty.
REQ-011 With FWFT=1, the first word written into an empty FIFO SHALL appear on rd_data in the cycle after the write edge.
REQ-012 overflow SHALL be 1 for the cycle after an edge with wr_en=1 and full=1, and 0 otherwise; underflow SHALL follow the same rule for rd_en=1 and empty=1.
REQ-013 Rejected accesses SHALL NOT alter the pointers, data_count, storage or rd_data.
REQ-014 Storage SHALL NOT require reset; the implementation SHALL never expose unwritten storage as valid data.

Reset
REQ-015 While rst_n=0 at an edge, the block SHALL set wr_ptr, rd_ptr and data_count to 0 and drive:
- rd_data = 0, rd_valid = 0.
- full = 0, empty = 1, almost_full = 0, almost_empty = 1.
- overflow = 0, underflow = 0.
REQ-016 Reset asserted mid-operation SHALL discard all contents; requests sampled in the reset cycle SHALL be ignored.

Verification (defaults: DEPTH=16, AFULL_TH=14, AEMPTY_TH=2)
REQ-017 The bench SHALL cover these directed scenarios:
- Write 0x01..0x10, one per cycle (FWFT=0) -> data_count 16, full=1, almost_full from count 14; 17th write -> overflow pulse, count stays 16.
- Read 16 from full -> rd_data 0x01..0x10 in order, each 1 cycle after its rd_en; extra read -> underflow pulse, rd_valid=0.
- Count 16 with simultaneous wr_en and rd_en -> read accepted, write rejected, overflow=1, count 15.
- Empty with simultaneous wr_en (0xA5) and rd_en -> underflow=1, count 1, then read returns 0xA5.
- FWFT=1: write 0x3C to empty -> next cycle rd_valid=1 and rd_data=0x3C with no rd_en; rd_en -> empty=1, rd_data=0.
- 40 mixed writes and reads across pointer wrap, then rst_n=0 for one edge mid-stream -> all outputs take reset values; the next write/read pair returns the new word.
